// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO reader: default data width, buffer depth, FSM state codes.
// No logic; a helper computes buffered-plus-in-flight word count.
// Optional transfer counter in the top is enabled by FIFO_RD_CNT_EN.
package fifo_rd_pkg;

   localparam int DW_DEF    = 8;
   localparam int BUF_DEPTH = 3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   // Words held in the buffer plus the one read that is still in flight.
   function automatic logic [2:0] fill_level(input logic [1:0] occ, input logic pend);
      return {1'b0, occ} + {2'b00, pend};
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// 3-entry in-order shift buffer; head entry always at index 0.
// Latency: a push is visible at the head one cycle later when the buffer was empty.
// Backpressure: push is ignored when full unless a pop frees a slot that same cycle.
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          pop,
   output logic [1:0]    occ,
   output logic [DW-1:0] head_dat
);

   logic [DW-1:0] r_mem     [BUF_DEPTH];
   logic [DW-1:0] w_mem_nxt [BUF_DEPTH];
   logic [1:0]    r_occ;
   logic [1:0]    w_occ_nxt;
   logic [1:0]    w_wr_idx;
   logic          w_pop;
   logic          w_push;

   // Next buffer contents: shift toward the head on pop, then write the tail slot.
   always_comb begin
      w_pop    = pop && (r_occ != 2'd0);
      w_push   = push && ((r_occ != 2'd3) || w_pop);
      w_wr_idx = w_pop ? (r_occ - 2'd1) : r_occ;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         w_mem_nxt[i] = r_mem[i];
      end
      if (w_pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            w_mem_nxt[i] = r_mem[i + 1];
         end
      end
      if (w_push) begin
         w_mem_nxt[w_wr_idx] = push_dat;
      end
      w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};
   end

   // Storage and occupancy; clear drops contents logically without touching data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_occ <= 2'd0;
      end else if (clr) begin
         r_occ <= 2'd0;
      end else begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= w_mem_nxt[i];
         end
         r_occ <= w_occ_nxt;
      end
   end

   assign occ      = r_occ;
   assign head_dat = r_mem[0];

endmodule

// File: rtl/fifo_reader.sv
// Reads a synchronous FIFO and presents its words as a valid/ready stream; FIFO_RD_CNT_EN adds xfer_cnt.
// Latency: 2 cycles from rd to m_valid; one word per cycle sustained.
// Backpressure: m_ready low fills a 3-entry buffer; rd stops once buffered + in-flight words reach 3.
module fifo_reader
   import fifo_rd_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          flush,
   input  logic          empty,
   input  logic [DW-1:0] dout,
   output logic          rd,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]   xfer_cnt
`endif
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_pend;
   logic [1:0] w_occ;
   logic [2:0] w_fill;
   logic       w_rd;
   logic       w_push;
   logic       w_xfer;

   assign w_fill = fill_level(w_occ, r_pend);

   // Read only when a slot is guaranteed for the returning word; m_ready is deliberately
   // absent so the strobe never depends on the downstream sink combinationally.
   assign w_rd   = rst && en && !empty && !flush && (w_fill <= 3'd2);
   assign rd     = w_rd;

   // A word returning from a read issued before a flush is dropped.
   assign w_push = r_pend && !flush;
   assign w_xfer = m_valid && m_ready;

   assign m_valid = (w_occ != 2'd0);

   fifo_rd_skid #(
      .DW (DW)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .push     (w_push),
      .push_dat (dout),
      .pop      (w_xfer),
      .occ      (w_occ),
      .head_dat (m_data)
   );

   // Track that FIFO read data arrives on dout in the cycle after rd.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_rd;
      end
   end

   // Mode FSM: RUN while enabled, DRAIN while disabled with words still owed, IDLE otherwise.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = en ? RUN : IDLE;
      end else begin
         case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN:     if (!en) w_state_nxt = (w_fill != 3'd0) ? DRAIN : IDLE;
            DRAIN: begin
               if (en)                    w_state_nxt = RUN;
               else if (w_fill == 3'd0)   w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [15:0] r_xfer_cnt;

   // Count completed stream transfers; wraps naturally, cleared along with the buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_xfer_cnt <= 16'd0;
      end else if (flush) begin
         r_xfer_cnt <= 16'd0;
      end else if (w_xfer) begin
         r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
   end

   assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural synchronous FIFO model.
module tb_fifo_reader;
   import fifo_rd_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic       empty;
   logic [7:0] dout = 8'h00;
   logic       rd;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   int total = 0;
   int bad = 0;

   logic [7:0] fmem [256];
   int rptr = 0;
   int wptr = 0;

   always #5 clk = ~clk;

   assign empty = (rptr == wptr);

   always @(posedge clk) begin
      if (rd && (rptr != wptr)) begin
         dout <= fmem[rptr & 255];
         rptr <= rptr + 1;
      end
   end

   fifo_reader #(.DW(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .empty   (empty),
      .dout    (dout),
      .rd      (rd),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
`ifdef FIFO_RD_CNT_EN
      ,
      .xfer_cnt(xfer_cnt)
`endif
   );

   task automatic load(input logic [7:0] first, input int n);
      logic [7:0] v;
      for (int i = 0; i < n; i++) begin
         v = first + 8'(i);
         fmem[(wptr + i) & 255] = v;
      end
      wptr = wptr + n;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%0b exp=0", rd); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", m_valid); end
      total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", m_data); end
      total++; if (dut.r_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
      total++; if (dut.r_pend !== 1'b0) begin bad++; $display("FAIL reset_pend got=%0b exp=0", dut.r_pend); end
`ifdef FIFO_RD_CNT_EN
      total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
`endif
      step();
      rst = 1'b1;
   endtask

   task automatic test_stream();
      int first = -1;
      int last_rd = -1;
      int nrd = 0;
      int nx = 0;
      logic [7:0] exp = 8'h01;
      load(8'h01, 15);
      m_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step();
         en = 1'b1;
         #1;
         total++; if (rd && empty) begin bad++; $display("FAIL stream_rd_empty cyc=%0d rd=%0b empty=%0b", c, rd, empty); end
         if (rd) begin
            if (first < 0) first = c;
            nrd++;
            last_rd = c;
         end
         if (m_valid) begin
            total++;
            if (m_data !== exp || c != first + 2 + nx) begin
               bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h exp_cyc=%0d", c, m_data, exp, first + 2 + nx);
            end
            exp++;
            nx++;
         end
      end
      en = 1'b0;
      total++; if (nrd != 15) begin bad++; $display("FAIL stream_rd_count got=%0d exp=15", nrd); end
      total++; if (last_rd - first != 14) begin bad++; $display("FAIL stream_rd_span got=%0d exp=14", last_rd - first); end
      total++; if (nx != 15) begin bad++; $display("FAIL stream_xfer_count got=%0d exp=15", nx); end
      repeat (3) step();
   endtask

   task automatic test_backpressure();
      int nrd = 0;
      logic [7:0] exp;
      load(8'h01, 5);
      m_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         en = 1'b1;
         #1;
         if (rd) nrd++;
      end
      total++; if (nrd != 3) begin bad++; $display("FAIL bp_rd_count got=%0d exp=3", nrd); end
      total++; if (dut.w_occ !== 2'd3) begin bad++; $display("FAIL bp_occ got=%0d exp=3", dut.w_occ); end
      total++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin bad++; $display("FAIL bp_hold got=%0b/%h exp=1/01", m_valid, m_data); end
      for (int c = 0; c < 10; c++) begin
         step();
         m_ready = 1'b1;
         #1;
         if (c < 5) begin
            exp = 8'h01 + 8'(c);
            total++;
            if (m_valid !== 1'b1 || m_data !== exp) begin
               bad++; $display("FAIL bp_order cyc=%0d got=%0b/%h exp=1/%h", c, m_valid, m_data, exp);
            end
         end
      end
      en = 1'b0;
      step();
      total++; if (m_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL bp_drained valid=%0b empty=%0b exp=0/1", m_valid, empty); end
   endtask

   task automatic test_drain();
      int nrd = 0;
      int nx = 0;
      bit seen_drain = 1'b0;
      logic [7:0] exp = 8'h21;
      load(8'h21, 5);
      m_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         step();
         en = (nrd < 5);
         #1;
         if (rd) nrd++;
         if (dut.r_state == DRAIN) seen_drain = 1'b1;
         if (m_valid) begin
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL drain_data got=%h exp=%h", m_data, exp); end
            exp++;
            nx++;
         end
      end
      total++; if (!seen_drain) begin bad++; $display("FAIL drain_state_seen got=0 exp=1"); end
      total++; if (nx != 5) begin bad++; $display("FAIL drain_count got=%0d exp=5", nx); end
      total++; if (dut.r_state !== IDLE || rd !== 1'b0) begin bad++; $display("FAIL drain_idle state=%0d rd=%0b exp=%0d/0", dut.r_state, rd, IDLE); end
   endtask

   task automatic test_flush();
      int nx = 0;
      logic [7:0] exp = 8'h34;
      load(8'h31, 5);
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         en = 1'b1;
         #1;
      end
      step();
      flush = 1'b1;
      #1;
      total++; if (dut.w_occ !== 2'd2 || dut.r_pend !== 1'b1) begin bad++; $display("FAIL flush_pre occ=%0d pend=%0b exp=2/1", dut.w_occ, dut.r_pend); end
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL flush_rd got=%0b exp=0", rd); end
      step();
      flush = 1'b0;
      m_ready = 1'b1;
      #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", m_valid); end
      total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL flush_state got=%0d exp=%0d", dut.r_state, RUN); end
      for (int c = 0; c < 10; c++) begin
         step();
         #1;
         if (m_valid) begin
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL flush_data got=%h exp=%h", m_data, exp); end
            exp++;
            nx++;
         end
      end
      en = 1'b0;
      total++; if (nx != 2) begin bad++; $display("FAIL flush_count got=%0d exp=2", nx); end
      step();
   endtask

   task automatic test_reset_mid();
      int nx = 0;
      logic [7:0] exp = 8'h43;
      load(8'h41, 4);
      m_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         en = 1'b1;
         #1;
      end
      step();
      rst = 1'b0;
      #1;
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL rstmid_rd got=%0b exp=0", rd); end
      step();
      rst = 1'b1;
      en = 1'b0;
      #1;
      total++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin bad++; $display("FAIL rstmid_out got=%0b/%h exp=0/00", m_valid, m_data); end
      total++; if (dut.r_state !== IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.r_state, IDLE); end
      for (int c = 0; c < 8; c++) begin
         step();
         en = 1'b1;
         m_ready = 1'b1;
         #1;
         if (m_valid) begin
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", m_data, exp); end
            exp++;
            nx++;
         end
      end
      en = 1'b0;
      total++; if (nx != 2) begin bad++; $display("FAIL rstmid_count got=%0d exp=2", nx); end
      step();
   endtask

`ifdef FIFO_RD_CNT_EN
   task automatic test_counter();
      int c = 0;
      total++; if (xfer_cnt !== 16'd2) begin bad++; $display("FAIL cnt_pre got=%0d exp=2", xfer_cnt); end
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL cnt_flush got=%0d exp=0", xfer_cnt); end
      wptr = wptr + 65537;
      m_ready = 1'b1;
      en = 1'b1;
      while (c < 70000 && !(empty && !m_valid && dut.r_pend == 1'b0 && c > 4)) begin
         step();
         c++;
      end
      en = 1'b0;
      total++; if (c >= 70000) begin bad++; $display("FAIL cnt_timeout cycles=%0d limit=70000", c); end
      total++; if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL cnt_wrap got=%0d exp=1", xfer_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_flush();
      test_reset_mid();
`ifdef FIFO_RD_CNT_EN
      test_counter();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
